// File: rtl/uart_pkg.sv
// Shared UART constants: byte width, default RX FIFO depth, receiver timing.
package uart_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned FIFO_DEPTH = 16;

  // Receiver bit timing (consumed by the receiver, kept here so both sides agree).
  localparam int unsigned CLK_HZ     = 50_000_000;
  localparam int unsigned BAUD       = 115_200;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DIVISOR    = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int unsigned SAMPLE_MID = OVERSAMPLE / 2;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x W register array: synchronous write port, combinational read port.
// Ports: i_clk, i_we/i_waddr/i_wdata (write), i_raddr/o_rdata (read).
module fifo_mem
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH = FIFO_DEPTH,
  parameter  int unsigned W     = BYTE_W,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] mem_q [DEPTH];

  // Storage carries no reset; validity is tracked by the parent's count.
  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind the UART receiver: drops framing-error frames (counted),
// flags overruns, presents bytes first-word-fall-through over valid/ready.
// Ports: i_clk, i_rst_n; receiver side i_data/i_valid/i_error; consumer side
// o_data/o_valid/i_ready; status o_count/o_full/o_empty/o_overrun/o_err_cnt;
// i_clr clears the sticky overrun flag and the error counter.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH = FIFO_DEPTH,
  parameter  int unsigned ECW   = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_valid,
  input  logic              i_error,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [AW:0]       o_count,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_overrun,
  output logic [ECW-1:0]    o_err_cnt,
  input  logic              i_clr
);

  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              valid_q, full_q, empty_q;
  logic              overrun_q, overrun_d;
  logic [ECW-1:0]    err_cnt_q, err_cnt_d;
  logic              wr_req, err_req, wr_acc, rd_acc, ovr_evt;
  logic [BYTE_W-1:0] rd_data;

  fifo_mem #(
    .DEPTH (DEPTH),
    .W     (BYTE_W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (wr_acc),
    .i_waddr (wr_ptr_q),
    .i_wdata (i_data),
    .i_raddr (rd_ptr_q),
    .o_rdata (rd_data)
  );

  // Handshake qualification and next-state for pointers, count and status.
  always_comb begin
    wr_req    = i_valid & ~i_error;
    err_req   = i_valid & i_error;
    rd_acc    = valid_q & i_ready;
    // A read in the same cycle frees the slot, so a full FIFO still accepts.
    wr_acc    = wr_req & (~full_q | rd_acc);
    ovr_evt   = wr_req & ~wr_acc;

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    err_cnt_d = err_cnt_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Clear takes priority over a same-cycle event.
    if (i_clr) begin
      overrun_d = 1'b0;
      err_cnt_d = '0;
    end else begin
      if (ovr_evt) overrun_d = 1'b1;
      if (err_req && (err_cnt_q != {ECW{1'b1}})) err_cnt_d = err_cnt_q + ECW'(1);
    end
  end

  // State and status registers; flags are decoded from the next count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      overrun_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      valid_q   <= (count_d != '0);
      full_q    <= (count_d == CW'(DEPTH));
      empty_q   <= (count_d == '0);
      overrun_q <= overrun_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Unreset storage is masked so an empty FIFO always shows zero.
  assign o_data    = valid_q ? rd_data : '0;
  assign o_valid   = valid_q;
  assign o_count   = count_q;
  assign o_full    = full_q;
  assign o_empty   = empty_q;
  assign o_overrun = overrun_q;
  assign o_err_cnt = err_cnt_q;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Byte buffer directly downstream of the UART receiver.
- Captures each received byte on the receiver's per-frame strobe and discards frames flagged with a framing error, counting them.
- Presents stored bytes to the consumer in first-word-fall-through order over a valid/ready handshake.
- Decouples the bit-rate receiver from slower or bursty consumer logic and reports overruns.

Parameters:
- DEPTH, 16, number of byte entries; power of two, minimum 2.
- AW, $clog2(DEPTH), pointer width; derived, never overridden.
- ECW, 8, width of the saturating error-frame counter.

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  asynchronous active-low reset
- i_data  input  8  received byte from receiver
- i_valid  input  1  one-cycle strobe: i_data/i_error valid for a completed frame
- i_error  input  1  framing error for the frame qualified by i_valid
- o_data  output  8  head-of-queue byte
- o_valid  output  1  o_data holds a stored byte
- i_ready  input  1  consumer accepts o_data this cycle
- o_count  output  AW+1  current occupancy, 0..DEPTH
- o_full  output  1  o_count == DEPTH
- o_empty  output  1  o_count == 0
- o_overrun  output  1  sticky: a good byte was dropped because the FIFO was full
- o_err_cnt  output  ECW  saturating count of frames dropped for i_error
- i_clr  input  1  synchronous clear of o_overrun and o_err_cnt; FIFO contents untouched

Behaviour:
- Reset (asynchronous on i_rst_n low; release synchronous to i_clk):
  - wr_ptr, rd_ptr and count = 0.
  - o_valid=0, o_empty=1, o_full=0, o_count=0, o_overrun=0, o_err_cnt=0, o_data=8'h00.
- Reset mid-operation: all contents discarded immediately. Storage array needs no reset; o_data is forced to 0 while empty.
- Write qualification:
  - wr_req = i_valid & ~i_error.
  - err_req = i_valid & i_error.
  - wr_acc = wr_req & (~o_full | rd_acc).
- Read: rd_acc = o_valid & i_ready. rd_acc with o_valid=0 is ignored and has no side effects.
- Storage: wr_acc writes i_data at wr_ptr, then wr_ptr += 1 mod DEPTH. rd_acc advances rd_ptr += 1 mod DEPTH. Pointers wrap naturally at AW bits.
- Count update: +1 on wr_acc only, -1 on rd_acc only, unchanged on both. Never exceeds DEPTH or drops below 0.
- Output timing:
  - o_data = mem[rd_ptr] and o_valid = (count != 0), both registered from count.
  - Byte written in cycle N to an empty FIFO shows o_valid=1 in cycle N+1.
  - o_data is stable while o_valid=1 and i_ready=0.
- Simultaneous read and write:
  - Full: both accepted, count stays DEPTH, no overrun.
  - Empty: read is ignored (o_valid=0); write accepted; count becomes 1.
- Overrun: wr_req while full with no rd_acc drops the byte and sets o_overrun=1 the next cycle. It stays set until i_clr or reset.
- Error frames: err_req never writes. o_err_cnt += 1 next cycle, saturating at 2^ECW-1 (no wrap).
- i_clr:
  - i_clr in the same cycle as err_req: clear wins, o_err_cnt=0.
  - i_clr in the same cycle as an overrun event: clear wins, o_overrun=0.
- o_full, o_empty and o_count are all derived from the registered count, so they change one cycle after the accepting edge.

Decomposition:
- Shared package uart_pkg holds BYTE_W=8 and the default DEPTH constant, alongside the receiver's divisor and sampling constants.
- One sub-module, fifo_mem: a DEPTH x 8 register array with a synchronous write port and a combinational read port, written by the parent.
- Pointers, count, flags and counters stay in uart_rx_fifo.

Test Plan:
- Reset then single frame: i_valid=1, i_data=8'hA5, i_error=0 at cycle 5 -> cycle 6 o_valid=1, o_data=8'hA5, o_count=1. With i_ready=1 at cycle 6 -> cycle 7 o_empty=1.
- Fill and overrun (DEPTH=16, i_ready=0): write 8'h00..8'h10 (17 bytes) -> o_full=1, o_count=16, o_overrun=1. Drain returns 8'h00..8'h0F in order; 8'h10 is absent.
- Full with simultaneous read and write: FIFO full and i_ready=1 while writing 8'h55 -> o_count stays 16, o_overrun stays 0, 8'h55 is read out last.
- Error frames: 3 strobes with i_error=1 (i_data=8'hFF) -> o_count unchanged, o_err_cnt=3. Then 300 error strobes -> o_err_cnt=255. i_clr -> 0.
- Pointer wrap: 40 writes of incrementing bytes with i_ready=1 each cycle -> output sequence matches 0..39 with no gaps; o_count never exceeds 2.
- Mid-operation reset: 5 bytes stored, i_rst_n pulsed low between clock edges -> o_valid, o_count and o_overrun go to 0 asynchronously. The next byte written, 8'h3C, is read first.
